// File: rtl/ram_sized.sv
// Byte-serial sized memory for the MIPS64 core: valid/ready request/response, one byte per clock,
// with a byte-output FIFO at IO_PUTC and a sticky halt latch at IO_HALT.
module ram_sized #(
   parameter int unsigned          MADDR_SZ = 32,
   parameter int unsigned          MEM_SZ   = 2**21,
   parameter int unsigned          DATA_W   = 64,
   parameter int unsigned          IO_DEPTH = 4,
   parameter logic [MADDR_SZ-1:0]  IO_PUTC  = 32'h104,
   parameter logic [MADDR_SZ-1:0]  IO_HALT  = 32'h108
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic [MADDR_SZ-1:0] req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                io_valid,
   input  logic                io_ready,
   output logic [7:0]          io_data,
   output logic                halt,
   output logic [7:0]          halt_code
);

   localparam int unsigned AW = $clog2(MEM_SZ);
   localparam int unsigned PW = $clog2(IO_DEPTH);

   typedef enum logic [1:0] {StIdle, StXfer, StErr, StResp} state_e;

   logic [7:0] mem [MEM_SZ];
   logic [7:0] fifo_q [IO_DEPTH];

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic [MADDR_SZ-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                halt_q, halt_d;
   logic [7:0]          code_q, code_d;
   logic [PW-1:0]       wptr_q, rptr_q;
   logic [PW:0]         count_q;

   logic [3:0]          req_n;
   logic                misaligned, out_of_range;
   logic [MADDR_SZ:0]   req_end;
   logic [MADDR_SZ-1:0] cur_addr;
   logic [7:0]          wbyte, mem_rd;
   logic [2:0]          last_cnt;
   logic                mem_we, push, pop, full, putc_hit;

   // Accept-time error check; the extended sum keeps addr+N from wrapping.
   assign req_n        = 4'd1 << req_size;
   assign misaligned   = |(req_addr[2:0] & 3'(req_n - 4'd1));
   assign req_end      = {1'b0, req_addr} + (MADDR_SZ+1)'(req_n);
   assign out_of_range = req_end > (MADDR_SZ+1)'(MEM_SZ);

   assign cur_addr = addr_q + MADDR_SZ'(cnt_q);
   assign wbyte    = wdata_q[{cnt_q, 3'b000} +: 8];
   assign mem_rd   = mem[cur_addr[AW-1:0]];
   assign last_cnt = 3'((4'd1 << size_q) - 4'd1);
   assign putc_hit = we_q && (cur_addr == IO_PUTC);

   assign io_valid = (count_q != '0);
   assign io_data  = io_valid ? fifo_q[rptr_q] : 8'h00;
   assign full     = (count_q == (PW+1)'(IO_DEPTH));
   assign pop      = io_valid && io_ready;

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign halt      = halt_q;
   assign halt_code = code_q;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      code_d  = code_q;
      mem_we  = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               cnt_d   = 3'd0;
               err_d   = misaligned || out_of_range;
               state_d = (misaligned || out_of_range) ? StErr : StXfer;
            end
         end
         StXfer: begin
            // A full FIFO blocks the PUTC byte unless a pop frees a slot on this same edge.
            if (!(putc_hit && full && !pop)) begin
               if (we_q) begin
                  mem_we = 1'b1;
                  push   = putc_hit;
                  if (cur_addr == IO_HALT) begin
                     halt_d = 1'b1;
                     code_d = wbyte;
                  end
               end else begin
                  rdata_d[{cnt_q, 3'b000} +: 8] = mem_rd;
               end
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == last_cnt) state_d = StResp;
            end
         end
         StErr:  state_d = StResp;
         StResp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 3'd0;
         halt_q  <= 1'b0;
         code_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
         code_q  <= code_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage arrays are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[cur_addr[AW-1:0]] <= wbyte;
      if (push)   fifo_q[wptr_q] <= wbyte;
   end

endmodule
